// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU requesters (IF, LS), the shared memory port and the arbiter.
// The arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata, mem_addr, mem_wdata, mem_wr, busy, owner
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata, mem_addr, mem_wdata, mem_wr, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store, hiding memory latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise LS has fixed priority over IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 3
) (
  input logic               i_clk,
  input logic               i_rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [2:0] LastCnt = 3'(MEM_LAT - 1);

  state_e            r_state;
  logic [2:0]        r_cnt;
  logic              r_owner;
  logic              r_we;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_ls_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_busy;

  logic w_any_req;
  logic w_grant_ls;

  assign w_any_req = bus.if_req | bus.ls_req;

`ifdef MEM_ARB_RR_EN
  // r_owner doubles as the last-owner register; on a tie the other requester wins
  assign w_grant_ls = bus.ls_req & (~bus.if_req | ~r_owner);
`else
  assign w_grant_ls = bus.ls_req;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= 3'd0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_ls_ack    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_owner    <= w_grant_ls;
            r_mem_addr <= w_grant_ls ? bus.ls_addr : bus.if_addr;
            if (w_grant_ls) begin
              r_mem_wdata <= bus.ls_wdata;
            end
            r_we     <= w_grant_ls & bus.ls_we;
            // strobe is the registered form of (write flag & cnt==0)
            r_mem_wr <= w_grant_ls & bus.ls_we;
            r_cnt    <= 3'd0;
            r_busy   <= 1'b1;
            r_state  <= StAccess;
          end
        end
        StAccess: begin
          r_mem_wr <= 1'b0;
          r_cnt    <= r_cnt + 3'd1;
          if (r_cnt == LastCnt) begin
            if (!r_owner) begin
              r_if_rdata <= bus.mem_rdata;
              r_if_ack   <= 1'b1;
            end else begin
              if (!r_we) begin
                r_ls_rdata <= bus.mem_rdata;
              end
              r_ls_ack <= 1'b1;
            end
            r_state <= StResp;
          end
        end
        StResp: begin
          r_if_ack <= 1'b0;
          r_ls_ack <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.if_ack    = r_if_ack;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_ack    = r_ls_ack;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.busy      = r_busy;
  assign bus.owner     = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner sequences and
// randomized traffic against a transaction-level schedule model. Honours MEM_ARB_RR_EN.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned L  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) u_if1 ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (u_if)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (u_if1)
  );

  // Memory: data only valid once the address has been stable for L cycles.
  logic [31:0] mem [64];
  logic        mem_init = 1'b1;
  int          age = 0;
  logic [31:0] prev_addr = '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[0]   <= 32'h0000_00E3;
      mem_init <= 1'b0;
    end else if (u_if.mem_wr) begin
      mem[u_if.mem_addr[7:2]] <= u_if.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (u_if.mem_addr != prev_addr) age <= 0;
    else if (age < 100) age <= age + 1;
    prev_addr <= u_if.mem_addr;
  end

  assign u_if.mem_rdata  = (age >= int'(L) - 1) ? mem[u_if.mem_addr[7:2]]
                                                 : (32'hBAD0_0000 | 32'(age));
  assign u_if1.mem_rdata = mem[u_if1.mem_addr[7:2]];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_busy"},   32'(u_if.busy), 0);
    chk({p, "_owner"},  32'(u_if.owner), 0);
    chk({p, "_if_ack"}, 32'(u_if.if_ack), 0);
    chk({p, "_ls_ack"}, 32'(u_if.ls_ack), 0);
    chk({p, "_mem_wr"}, 32'(u_if.mem_wr), 0);
    chk({p, "_addr"},   u_if.mem_addr, 0);
    chk({p, "_wdata"},  u_if.mem_wdata, 0);
    chk({p, "_if_rd"},  u_if.if_rdata, 0);
    chk({p, "_ls_rd"},  u_if.ls_rdata, 0);
  endtask

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic do_access(input vec_t v, output int ack_cyc, output int wr_cyc,
                           output int wr_cnt, output int addr_bad, output int stray,
                           output logic [31:0] wd, output logic [31:0] rd);
    ack_cyc = 0; wr_cyc = 0; wr_cnt = 0; addr_bad = 0; stray = 0; wd = '0; rd = '0;
    if (v.is_ls) begin
      u_if.ls_req = 1'b1; u_if.ls_we = v.we; u_if.ls_addr = v.addr; u_if.ls_wdata = v.wdata;
    end else begin
      u_if.if_req = 1'b1; u_if.if_addr = v.addr;
    end
    for (int c = 1; c <= 20 && ack_cyc == 0; c++) begin
      @(negedge clk);
      if (u_if.mem_wr) begin
        wr_cnt++;
        if (wr_cyc == 0) wr_cyc = c;
        wd = u_if.mem_wdata;
      end
      if (c <= int'(L) && u_if.mem_addr !== v.addr) addr_bad++;
      if (v.is_ls ? u_if.if_ack : u_if.ls_ack) stray++;
      if (v.is_ls ? u_if.ls_ack : u_if.if_ack) begin
        ack_cyc = c;
        rd = v.is_ls ? u_if.ls_rdata : u_if.if_rdata;
      end
      // Post-grant changes must not disturb the access in flight.
      u_if.if_addr  = $urandom;
      u_if.ls_addr  = $urandom;
      u_if.ls_wdata = $urandom;
      u_if.ls_we    = 1'($urandom_range(0, 1));
    end
    u_if.if_req = 1'b0; u_if.ls_req = 1'b0; u_if.ls_we = 1'b0;
    @(negedge clk);
  endtask

  int ack_cyc, wr_cyc, wr_cnt, addr_bad, stray;
  logic [31:0] wd, rd;
  int if_c, ls_c, a1, a2, n_if, n_ls, n_ack, alt_bad;
  bit if_drop, ls_drop, who, last_who, first_who;
  logic [31:0] if_d, ls_d, d1, d2;

  // Reference-model state for the random phase.
  logic [31:0] ref_mem [64];
  bit          act, m_owner, m_we, if_pend, if_gr, ls_pend, ls_gr, gls, in_acc, in_resp;
  int          acc_start;
  logic [31:0] m_addr, m_wdata, m_pend, m_if_rd, m_ls_rd;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.if_req = 0; u_if.if_addr = 0; u_if.ls_req = 0; u_if.ls_we = 0;
    u_if.ls_addr = 0; u_if.ls_wdata = 0;
    u_if1.if_req = 0; u_if1.if_addr = 0; u_if1.ls_req = 0; u_if1.ls_we = 0;
    u_if1.ls_addr = 0; u_if1.ls_wdata = 0;

    vecs[0] = '{is_ls: 0, we: 0, addr: 32'h0,  wdata: 32'h0,         exp_rdata: 32'h0000_00E3};
    vecs[1] = '{is_ls: 1, we: 1, addr: 32'h40, wdata: 32'hDEAD_BEEF, exp_rdata: 32'h0};
    vecs[2] = '{is_ls: 1, we: 0, addr: 32'h40, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
    vecs[3] = '{is_ls: 0, we: 0, addr: 32'h40, wdata: 32'h0,         exp_rdata: 32'hDEAD_BEEF};
    vecs[4] = '{is_ls: 1, we: 1, addr: 32'h44, wdata: 32'h1234_5678, exp_rdata: 32'hDEAD_BEEF};
    vecs[5] = '{is_ls: 0, we: 0, addr: 32'h8,  wdata: 32'h0,         exp_rdata: 32'hA500_0002};
    vecs[6] = '{is_ls: 1, we: 0, addr: 32'h44, wdata: 32'h0,         exp_rdata: 32'h1234_5678};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // MEM_LAT=1 instance: back-to-back IF reads.
    u_if1.if_addr = 32'h0; u_if1.if_req = 1'b1; a1 = 0; a2 = 0;
    for (int c = 1; c <= 12 && a2 == 0; c++) begin
      @(negedge clk);
      if (u_if1.if_ack) begin
        if (a1 == 0) begin
          a1 = c; d1 = u_if1.if_rdata; u_if1.if_addr = 32'h4;
        end else begin
          a2 = c; d2 = u_if1.if_rdata;
        end
      end
    end
    u_if1.if_req = 1'b0;
    @(negedge clk);
    chk("lat1_ack1_cyc", a1, 2);
    chk("lat1_ack2_cyc", a2, 5);
    chk("lat1_rdata1", d1, 32'h0000_00E3);
    chk("lat1_rdata2", d2, 32'hA500_0001);

    for (int i = 0; i < 7; i++) begin
      do_access(vecs[i], ack_cyc, wr_cyc, wr_cnt, addr_bad, stray, wd, rd);
      chk($sformatf("v%0d_ack_cyc", i), ack_cyc, L + 1);
      chk($sformatf("v%0d_wr_cyc", i), wr_cyc, vecs[i].we ? 1 : 0);
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt, vecs[i].we ? 1 : 0);
      chk($sformatf("v%0d_addr_bad", i), addr_bad, 0);
      chk($sformatf("v%0d_stray_ack", i), stray, 0);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].we) chk($sformatf("v%0d_wdata", i), wd, vecs[i].wdata);
    end

    // Contention: both rise together, each dropped one cycle after its own ack.
    u_if.if_addr = 32'h0; u_if.ls_addr = 32'h8; u_if.ls_we = 1'b0;
    u_if.if_req = 1'b1; u_if.ls_req = 1'b1;
    if_c = 0; ls_c = 0; if_drop = 0; ls_drop = 0;
    for (int c = 1; c <= 25 && (if_c == 0 || ls_c == 0); c++) begin
      @(negedge clk);
      if (if_drop) begin u_if.if_req = 1'b0; if_drop = 0; end
      if (ls_drop) begin u_if.ls_req = 1'b0; ls_drop = 0; end
      if (u_if.if_ack && if_c == 0) begin if_c = c; if_d = u_if.if_rdata; if_drop = 1; end
      if (u_if.ls_ack && ls_c == 0) begin ls_c = c; ls_d = u_if.ls_rdata; ls_drop = 1; end
    end
    u_if.if_req = 1'b0; u_if.ls_req = 1'b0;
    @(negedge clk);
`ifdef MEM_ARB_RR_EN
    chk("cont_if_ack_cyc", if_c, L + 1);
    chk("cont_ls_ack_cyc", ls_c, 2 * L + 3);
`else
    chk("cont_ls_ack_cyc", ls_c, L + 1);
    chk("cont_if_ack_cyc", if_c, 2 * L + 3);
`endif
    chk("cont_if_rdata", if_d, 32'h0000_00E3);
    chk("cont_ls_rdata", ls_d, 32'hA500_0002);

    // Fairness / starvation: both held for three access slots.
    u_if.if_addr = 32'h0; u_if.ls_addr = 32'h8; u_if.if_req = 1'b1; u_if.ls_req = 1'b1;
    n_if = 0; n_ls = 0; n_ack = 0; alt_bad = 0; last_who = 0; first_who = 0;
    for (int c = 1; c <= 3 * int'(L + 2); c++) begin
      @(negedge clk);
      if (u_if.if_ack || u_if.ls_ack) begin
        who = u_if.ls_ack;
        if (who) n_ls++; else n_if++;
        if (n_ack > 0 && who == last_who) alt_bad++;
        if (n_ack == 0) first_who = who;
        last_who = who;
        n_ack++;
      end
    end
    u_if.if_req = 1'b0; u_if.ls_req = 1'b0;
    @(negedge clk);
    chk("fair_n_ack", n_ack, 3);
`ifdef MEM_ARB_RR_EN
    chk("fair_alternate", alt_bad, 0);
    chk("fair_first_is_if", 32'(first_who), 0);
`else
    chk("starve_if_acks", n_if, 0);
    chk("starve_ls_acks", n_ls, 3);
`endif

    // Reset in cycle 2 of a read.
    u_if.if_addr = 32'h8; u_if.if_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_reset("midrst");
    u_if.if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (L + 3) begin
      @(negedge clk);
      if (u_if.if_ack || u_if.ls_ack || u_if.busy) stray++;
    end
    chk("midrst_no_ack", stray, 0);
    vecs[0] = '{is_ls: 0, we: 0, addr: 32'h4, wdata: 32'h0, exp_rdata: 32'hA500_0001};
    do_access(vecs[0], ack_cyc, wr_cyc, wr_cnt, addr_bad, stray, wd, rd);
    chk("postrst_ack_cyc", ack_cyc, L + 1);
    chk("postrst_rdata", rd, 32'hA500_0001);

    // Random traffic against the schedule model, starting from a fresh reset.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
    act = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_pend = 0;
    m_if_rd = 0; m_ls_rd = 0; acc_start = 0;
    if_pend = 0; if_gr = 0; ls_pend = 0; ls_gr = 0;
    for (int n = 0; n < 400; n++) begin
      in_acc  = act && n >= acc_start && n < acc_start + int'(L);
      in_resp = act && n == acc_start + int'(L);
      if (in_resp) begin
        if (!m_owner) m_if_rd = m_pend;
        else if (!m_we) m_ls_rd = m_pend;
      end
      chk("rnd_busy",   32'(u_if.busy), 32'(in_acc | in_resp));
      chk("rnd_if_ack", 32'(u_if.if_ack), 32'(in_resp & !m_owner));
      chk("rnd_ls_ack", 32'(u_if.ls_ack), 32'(in_resp & m_owner));
      chk("rnd_mem_wr", 32'(u_if.mem_wr), 32'(act && m_we && n == acc_start));
      chk("rnd_owner",  32'(u_if.owner), 32'(m_owner));
      chk("rnd_addr",   u_if.mem_addr, m_addr);
      chk("rnd_if_rd",  u_if.if_rdata, m_if_rd);
      chk("rnd_ls_rd",  u_if.ls_rdata, m_ls_rd);
      if (in_acc && m_we) chk("rnd_wdata", u_if.mem_wdata, m_wdata);

      if (in_resp) begin
        if (m_owner) ls_pend = 0; else if_pend = 0;
      end
      if (if_pend && !if_gr && $urandom_range(0, 15) == 0) if_pend = 0;
      if (ls_pend && !ls_gr && $urandom_range(0, 15) == 0) ls_pend = 0;
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1; if_gr = 0; u_if.if_addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1; ls_gr = 0;
        u_if.ls_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        u_if.ls_we    = 1'($urandom_range(0, 1));
        u_if.ls_wdata = $urandom;
      end
      if (if_pend && if_gr) u_if.if_addr = $urandom;
      if (ls_pend && ls_gr) begin
        u_if.ls_addr = $urandom; u_if.ls_wdata = $urandom; u_if.ls_we = 1'($urandom_range(0, 1));
      end
      u_if.if_req = if_pend;
      u_if.ls_req = ls_pend;

      if ((!act || n >= acc_start + int'(L) + 1) && (if_pend || ls_pend)) begin
`ifdef MEM_ARB_RR_EN
        gls = (if_pend && ls_pend) ? !m_owner : ls_pend;
`else
        gls = ls_pend;
`endif
        act = 1; acc_start = n + 1; m_owner = gls;
        if (gls) begin
          ls_gr = 1; m_addr = u_if.ls_addr; m_we = u_if.ls_we; m_wdata = u_if.ls_wdata;
          if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
          else m_pend = ref_mem[m_addr[7:2]];
        end else begin
          if_gr = 1; m_addr = u_if.if_addr; m_we = 0; m_pend = ref_mem[m_addr[7:2]];
        end
      end
      @(negedge clk);
    end
    u_if.if_req = 1'b0; u_if.ls_req = 1'b0;
    repeat (L + 3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Sequences the single shared memory port of the multicycle CPU between two requesters:
  - the instruction-fetch path (IF, read-only);
  - the load/store path (LS, read or write).
- Accepts one request at a time and drives the memory address, write strobe and write data.
- Waits out the fixed memory read latency, then returns the read data with a one-cycle acknowledge.
- Sits between the control unit's fetch/memory-access sequencing and the memory block, so the control FSM no longer hand-counts memory wait cycles.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 3, cycles from address presentation to valid mem_rdata; legal range 1..7
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address, sampled at grant
- if_ack  out  1  one-cycle pulse; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetch read data, registered
- ls_req  in  1  load/store request; held until ls_ack
- ls_we  in  1  1 = write, 0 = read; sampled at grant
- ls_addr  in  ADDR_W  load/store address, sampled at grant
- ls_wdata  in  DATA_W  write data, sampled at grant
- ls_ack  out  1  one-cycle completion pulse
- ls_rdata  out  DATA_W  load read data, registered
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wr  out  1  memory write strobe (ReadWrite), 1 = write
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in ACCESS and RESP
- owner  out  1  0 = IF, 1 = LS; last granted requester

## Operation
- States: IDLE, ACCESS, RESP. Wait counter cnt is 3 bits.
- IDLE:
  - If any request is high, arbitrate and latch the winner's address, write data and write flag (IF is always read).
  - Set owner, clear cnt, go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS:
  - mem_addr and mem_wdata come from the latched registers.
  - mem_wr = latched write flag AND cnt==0, so a write strobe lasts exactly one cycle.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1, capture mem_rdata into the owner's rdata register (reads only), set the owner's ack and go to RESP.
- RESP:
  - Owner's ack is high for this single cycle; go to IDLE next edge.
  - Requests are ignored in RESP.
- Arbitration (default): fixed priority, LS over IF.
- Requests are sampled only in IDLE:
  - a request dropped before grant produces no access;
  - a request dropped after grant still completes and still acks.
- Writes complete with the same timing as reads. ls_rdata is unchanged by a write. if_rdata is never written by LS.
- Address, data and we changes after grant have no effect on the access in flight.
- Reset (asserted, any state, asynchronous):
  - state=IDLE, cnt=0, owner=0;
  - if_ack=ls_ack=0, mem_wr=0, busy=0;
  - mem_addr, mem_wdata, if_rdata, ls_rdata = 0.
  - An in-flight access is abandoned with no ack.

## Timing
- Cycle 0: request high in IDLE; grant at the end of cycle 0.
- Cycles 1..MEM_LAT: ACCESS, address on mem_addr; for a write, mem_wr=1 in cycle 1 only.
- Cycle MEM_LAT+1: ack=1, rdata valid (registered); busy=1.
- Cycle MEM_LAT+2: IDLE; a held request is granted at the end of this cycle.
  - Back-to-back throughput: one access per MEM_LAT+2 cycles.
- MEM_LAT=1: a single ACCESS cycle; ack in cycle 2.
- mem_addr and mem_wdata hold their last value in IDLE and RESP. No output glitches, because all outputs are registered or decoded from registered state.
- Simultaneous if_req and ls_req in IDLE: a single grant per the arbitration rule; the loser waits and is granted at the next IDLE.

## Configuration
- MEM_ARB_RR_EN, compiled in: round-robin arbitration.
  - A last-owner register is updated at every grant.
  - On a tie, the requester that was not granted last wins.
  - After reset, the tie goes to LS.
  - A lone requester is always granted.
- MEM_ARB_RR_EN, compiled out: fixed priority, LS over IF; IF can be starved by continuous LS requests.

## Test plan
- Reset/read: release reset, memory returns 32'h0000_00E3 for address 0x0, if_req=1 with if_addr=0x0 → mem_addr=0x0 in cycles 1-3, if_ack=1 with if_rdata=0x0000_00E3 in cycle 4 only, mem_wr=0 throughout.
- Write: ls_req=1, ls_we=1, ls_addr=0x40, ls_wdata=0xDEAD_BEEF → mem_wr=1 in cycle 1 only with mem_addr=0x40 and mem_wdata=0xDEAD_BEEF, ls_ack in cycle 4, ls_rdata unchanged.
- Contention: if_req and ls_req rise in the same cycle, requests held and each dropped one cycle after its own ack →
  - fixed priority: LS acked in cycle 4, IF acked in cycle 9;
  - with MEM_ARB_RR_EN after a prior LS grant: IF acked first.
- Starvation/fairness: ls_req held high for 3 accesses alongside if_req →
  - without the macro: if_ack is never asserted during those accesses;
  - with the macro: IF and LS acks alternate.
- Reset mid-access: assert reset in cycle 2 of a read → all outputs are at reset values immediately (asynchronously); no ack after release; a new if_req is granted normally.
- MEM_LAT=1 build: back-to-back IF reads at 0x0 and 0x4 → acks in cycles 2 and 5.
